// File: rtl/score_accumulator_pkg.sv
// Shared definitions for the output-layer score accumulator: class count,
// class index width, FSM encoding and the packed Num field layout.
package score_accumulator_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int CLASS_IDX_W = 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Class k occupies Num[field_lsb(k, w) +: w].
  function automatic int field_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/score_accumulator_acc_add.sv
// Signed accumulator adder, combinational; the increment is sign-extended to the sum width.
// Wraps modulo 2^NUM_SIZE, or saturates and reports it when SCORE_ACC_SAT_EN is defined.
module acc_add #(
  parameter int NUM_SIZE = 26,
  parameter int IN_SIZE  = 16
) (
  input  logic [NUM_SIZE-1:0] acc_i,
  input  logic [IN_SIZE-1:0]  inc_i,
  output logic [NUM_SIZE-1:0] sum_o
`ifdef SCORE_ACC_SAT_EN
  ,
  output logic                sat_o
`endif
);

`ifdef SCORE_ACC_SAT_EN
  logic [NUM_SIZE:0] wide_sum;
  logic              ovf;

  // One guard bit: overflow shows up as disagreement between the top two bits.
  assign wide_sum = {acc_i[NUM_SIZE-1], acc_i}
                  + {{(NUM_SIZE + 1 - IN_SIZE){inc_i[IN_SIZE-1]}}, inc_i};
  assign ovf      = wide_sum[NUM_SIZE] ^ wide_sum[NUM_SIZE-1];
  assign sat_o    = ovf;

  always_comb begin
    sum_o = wide_sum[NUM_SIZE-1:0];
    if (ovf) begin
      sum_o = wide_sum[NUM_SIZE] ? {1'b1, {(NUM_SIZE-1){1'b0}}}
                                 : {1'b0, {(NUM_SIZE-1){1'b1}}};
    end
  end
`else
  logic [NUM_SIZE-1:0] inc_ext;

  assign inc_ext = {{(NUM_SIZE - IN_SIZE){inc_i[IN_SIZE-1]}}, inc_i};
  assign sum_o   = acc_i + inc_ext;
`endif

endmodule

// File: rtl/score_accumulator.sv
// Per-class running sums of a tagged partial-product stream; Num/NumValid 1 cycle after the InLast beat.
// InReady drops while a frame is held for the argmax stage; SCORE_ACC_SAT_EN selects saturating adds.
module score_accumulator
  import score_accumulator_pkg::*;
#(
  parameter int NUM_SIZE = 26,
  parameter int IN_SIZE  = 16
) (
  input  logic                            clk,
  input  logic                            GlobalReset,
  input  logic                            InValid,
  output logic                            InReady,
  input  logic [CLASS_IDX_W-1:0]          InClass,
  input  logic [IN_SIZE-1:0]              InData,
  input  logic                            InLast,
  output logic [NUM_SIZE*NUM_CLASSES-1:0] Num,
  output logic                            NumValid,
  input  logic                            NumReady,
  output logic                            BadClass,
  output logic [15:0]                     BeatCount
`ifdef SCORE_ACC_SAT_EN
  ,
  output logic                            SatFlag
`endif
);

  state_e                            state_q, state_d;
  logic [NUM_SIZE-1:0]               acc_q [NUM_CLASSES];
  logic [NUM_SIZE-1:0]               acc_d [NUM_CLASSES];
  logic [NUM_SIZE*NUM_CLASSES-1:0]   num_q, num_d;
  logic                              bad_q, bad_d;
  logic [15:0]                       beat_q, beat_d;
  logic [NUM_SIZE-1:0]               add_op;
  logic [NUM_SIZE-1:0]               add_sum;
  logic                              class_ok;
  logic                              accept;

  assign class_ok = (InClass < CLASS_IDX_W'(NUM_CLASSES));
  assign accept   = InValid && (state_q == ACCUM);

  // Single shared adder; out-of-range classes read zero and never write back.
  always_comb begin
    add_op = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (InClass == CLASS_IDX_W'(k)) add_op = acc_q[k];
    end
  end

`ifdef SCORE_ACC_SAT_EN
  logic add_sat;
  logic sat_q, sat_d;

  acc_add #(.NUM_SIZE(NUM_SIZE), .IN_SIZE(IN_SIZE)) u_acc_add (
    .acc_i (add_op),
    .inc_i (InData),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  always_comb begin
    sat_d = sat_q;
    if (accept && class_ok && add_sat) sat_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) sat_q <= 1'b0;
    else              sat_q <= sat_d;
  end

  assign SatFlag = sat_q;
`else
  acc_add #(.NUM_SIZE(NUM_SIZE), .IN_SIZE(IN_SIZE)) u_acc_add (
    .acc_i (add_op),
    .inc_i (InData),
    .sum_o (add_sum)
  );
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    num_d   = num_q;
    bad_d   = bad_q;
    beat_d  = beat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          beat_d = beat_q + 16'd1;
          if (class_ok) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
              if (InClass == CLASS_IDX_W'(k)) acc_d[k] = add_sum;
            end
          end else begin
            bad_d = 1'b1;
          end
          // Snapshot includes the final beat's add.
          if (InLast) begin
            state_d = HOLD;
            for (int k = 0; k < NUM_CLASSES; k++) begin
              num_d[field_lsb(k, NUM_SIZE) +: NUM_SIZE] = acc_d[k];
            end
          end
        end
      end
      HOLD: begin
        if (NumReady) begin
          state_d = ACCUM;
          beat_d  = '0;
          for (int k = 0; k < NUM_CLASSES; k++) acc_d[k] = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state_q <= ACCUM;
      num_q   <= '0;
      bad_q   <= 1'b0;
      beat_q  <= '0;
      for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      bad_q   <= bad_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
    end
  end

  assign InReady   = (state_q == ACCUM);
  assign NumValid  = (state_q == HOLD);
  assign Num       = num_q;
  assign BadClass  = bad_q;
  assign BeatCount = beat_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Randomized and directed bench for score_accumulator against a plain-arithmetic class-sum model.
module tb_score_accumulator;

  localparam int NS = 26;
  localparam int IS = 16;
  localparam int NC = 10;

  logic              clk = 1'b0;
  logic              GlobalReset;
  logic              InValid;
  logic              InReady;
  logic [3:0]        InClass;
  logic [IS-1:0]     InData;
  logic              InLast;
  logic [NS*NC-1:0]  Num;
  logic              NumValid;
  logic              NumReady;
  logic              BadClass;
  logic [15:0]       BeatCount;
`ifdef SCORE_ACC_SAT_EN
  logic              SatFlag;
`endif

  score_accumulator #(.NUM_SIZE(NS), .IN_SIZE(IS)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .InValid     (InValid),
    .InReady     (InReady),
    .InClass     (InClass),
    .InData      (InData),
    .InLast      (InLast),
    .Num         (Num),
    .NumValid    (NumValid),
    .NumReady    (NumReady),
    .BadClass    (BadClass),
    .BeatCount   (BeatCount)
`ifdef SCORE_ACC_SAT_EN
    ,
    .SatFlag     (SatFlag)
`endif
  );

  always #5 clk = ~clk;

  int     nvec = 0;
  int     nerr = 0;
  longint msum [NC];
  longint mbeats;
  longint mbad;
  longint msat;

  task automatic chk(input string tag, input longint obs, input longint exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on unbounded integers, reduced to the NS-bit score range.
  function automatic longint fold(input longint x, input bit count_sat);
    longint m = longint'(1) << NS;
    longint r;
`ifdef SCORE_ACC_SAT_EN
    r = x;
    if (x > m / 2 - 1) r = m / 2 - 1;
    if (x < -(m / 2))  r = -(m / 2);
    if (r != x && count_sat) msat = 1;
`else
    r = x % m;
    if (r >= m / 2)       r -= m;
    else if (r < -(m / 2)) r += m;
`endif
    return r;
  endfunction

  function automatic longint fld(input int k);
    logic [NS-1:0] f;
    f = Num[k*NS +: NS];
    return longint'($signed(f));
  endfunction

  task automatic model_clear_frame();
    for (int k = 0; k < NC; k++) msum[k] = 0;
    mbeats = 0;
  endtask

  task automatic model_reset();
    model_clear_frame();
    mbad = 0;
    msat = 0;
  endtask

  task automatic check_fields(input string tag);
    for (int k = 0; k < NC; k++) chk($sformatf("%s_f%0d", tag, k), fld(k), msum[k]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_num_valid"}, NumValid, 0);
    chk({tag, "_in_ready"}, InReady, 1);
    chk({tag, "_beats"}, BeatCount, 0);
    chk({tag, "_bad"}, BadClass, 0);
`ifdef SCORE_ACC_SAT_EN
    chk({tag, "_sat"}, SatFlag, 0);
`endif
    for (int k = 0; k < NC; k++) chk($sformatf("%s_f%0d", tag, k), fld(k), 0);
  endtask

  // Presents one beat, waits (bounded) for acceptance, updates the model.
  task automatic send_beat(input int cls, input longint data, input bit last, output int stalls);
    stalls  = 0;
    InValid = 1'b1;
    InClass = cls[3:0];
    InData  = data[IS-1:0];
    InLast  = last;
    while (!InReady && stalls < 200) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!InReady) begin
      chk("accept_timeout", InReady, 1);
      InValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    InLast  = 1'b0;
    mbeats = (mbeats + 1) & 64'hFFFF;
    if (cls < NC) msum[cls] = fold(msum[cls] + data, 1'b1);
    else          mbad = 1;
  endtask

  task automatic frame_end(input int hold_cycles, input bit poke_in_hold);
    chk("num_valid", NumValid, 1);
    check_fields("frame");
    chk("beat_count", BeatCount, mbeats);
    chk("bad_class", BadClass, mbad);
`ifdef SCORE_ACC_SAT_EN
    chk("sat_flag", SatFlag, msat);
`endif
    if (poke_in_hold) begin
      InValid = 1'b1; InClass = 4'd5; InData = 16'd77; InLast = 1'b1;
    end
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", InReady, 0);
      chk("hold_num_valid", NumValid, 1);
      chk("hold_beats", BeatCount, mbeats);
      check_fields("hold");
    end
    InValid = 1'b0; InLast = 1'b0;
    NumReady = 1'b1;
    @(posedge clk); #1;
    NumReady = 1'b0;
    chk("post_num_valid", NumValid, 0);
    chk("post_in_ready", InReady, 1);
    chk("post_beats", BeatCount, 0);
    model_clear_frame();
  endtask

  function automatic longint rnd_data();
    logic [IS-1:0] d;
    d = IS'($urandom);
    return longint'($signed(d));
  endfunction

  function automatic int rnd_class();
    if ($urandom_range(0, 7) == 0) return 10 + int'($urandom_range(0, 5));
    return int'($urandom_range(0, NC - 1));
  endfunction

  initial begin
    int st;
    GlobalReset = 1'b0;
    InValid = 1'b0; InClass = '0; InData = '0; InLast = 1'b0; NumReady = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 GlobalReset = 1'b1;
    check_zero("reset");

    // Basic frame, then a 5-cycle hold with upstream pushing.
    send_beat(3, 5, 1'b0, st);
    send_beat(3, -2, 1'b0, st);
    send_beat(7, 100, 1'b1, st);
    chk("dir_f3", fld(3), 3);
    chk("dir_f7", fld(7), 100);
    chk("dir_beats", BeatCount, 3);
    frame_end(5, 1'b1);

    // Out-of-range class: counted, flagged, no accumulator touched.
    send_beat(12, 9, 1'b0, st);
    send_beat(0, 1, 1'b1, st);
    chk("bad_set", BadClass, 1);
    chk("bad_f0", fld(0), 1);
    frame_end(1, 1'b0);
    send_beat(4, -3, 1'b1, st);
    chk("bad_sticky", BadClass, 1);
    frame_end(0, 1'b0);

    // Push class 0 to the positive limit, then step over it.
    for (int i = 0; i < 1024; i++) send_beat(0, 32767, 1'b0, st);
    send_beat(0, 1023, 1'b0, st);
    send_beat(0, 1, 1'b1, st);
`ifdef SCORE_ACC_SAT_EN
    chk("limit_f0", fld(0), (longint'(1) << (NS - 1)) - 1);
    chk("limit_sat", SatFlag, 1);
`else
    chk("limit_f0", fld(0), -(longint'(1) << (NS - 1)));
`endif
    chk("limit_beats", BeatCount, 1026);
    frame_end(2, 1'b0);

    // Reset in the middle of a frame discards it.
    for (int i = 0; i < 4; i++) send_beat(rnd_class(), rnd_data(), 1'b0, st);
    GlobalReset = 1'b0;
    @(posedge clk); #1;
    GlobalReset = 1'b1;
    model_reset();
    check_zero("midrst");
    send_beat(2, -7, 1'b1, st);
    chk("midrst_f2", fld(2), -7);
    frame_end(0, 1'b0);

    // Back-to-back frames with NumReady tied high: exactly one bubble each.
    NumReady = 1'b1;
    for (int f = 0; f < 3; f++) begin
      int nb;
      nb = int'($urandom_range(1, 5));
      for (int b = 0; b < nb; b++) begin
        send_beat(rnd_class(), rnd_data(), b == nb - 1, st);
        if (f > 0 && b == 0) chk("b2b_bubble", st, 1);
      end
      chk("b2b_num_valid", NumValid, 1);
      check_fields("b2b");
      chk("b2b_beats", BeatCount, mbeats);
      model_clear_frame();
    end
    @(posedge clk); #1;
    chk("b2b_pulse_end", NumValid, 0);
    chk("b2b_ready_back", InReady, 1);
    NumReady = 1'b0;

    // Random frames with idle gaps and variable downstream delay.
    for (int f = 0; f < 8; f++) begin
      int nb;
      nb = int'($urandom_range(1, 8));
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_beat(rnd_class(), rnd_data(), b == nb - 1, st);
      end
      frame_end(int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
